// File: rtl/axi_bridge_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite to AXI4 bridge.
package axi_bridge_pkg;

   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [1:0] RESP_SLVERR   = 2'b10;
   localparam logic [1:0] RESP_DECERR   = 2'b11;
   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_BRESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA, R_RESP} r_state_t;

endpackage

// File: rtl/axil_to_axi_bridge_if.sv
// AXI4-Lite and AXI4 bus bundles used by the bridge; master/slave modports
// give the initiator and target views of each bus.
interface axil_if #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

interface axi_if #(
   parameter int ID_WIDTH   = 8,
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;
   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
             wdata, wstrb, wlast, wvalid, bready,
             arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
      input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
             wdata, wstrb, wlast, wvalid, bready,
             arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
      output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axil_to_axi_bridge.sv
// AXI4-Lite slave to single-beat AXI4 master bridge, independent read/write FSMs.
// Optional AXIL_TO_AXI_BRIDGE_ALIGN_CHECK_EN answers misaligned accesses locally with SLVERR.
module axil_to_axi_bridge
   import axi_bridge_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 20,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8,
   parameter int WRITE_ID   = 0,
   parameter int READ_ID    = 0
) (
   input logic   clk,
   input logic   rst,
   axil_if.slave s_axil,
   axi_if.master m_axi
);

   localparam int         ALIGN_LSB = $clog2(STRB_WIDTH);
   localparam logic [2:0] AXI_SIZE  = 3'(ALIGN_LSB);

   w_state_t              w_state_r, w_next_s;
   logic                  awready_s, bready_s, w_misalign_s;
   logic [ADDR_WIDTH-1:0] aw_addr_r;
   logic [2:0]            aw_prot_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic [STRB_WIDTH-1:0] wstrb_r;
   logic                  awvalid_r, wvalid_r;
   logic [1:0]            bresp_r;

   r_state_t              r_state_r, r_next_s;
   logic                  arready_s, rready_s, r_misalign_s;
   logic [ADDR_WIDTH-1:0] ar_addr_r;
   logic [2:0]            ar_prot_r;
   logic                  arvalid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [1:0]            rresp_r;
   logic                  unused_s;

`ifdef AXIL_TO_AXI_BRIDGE_ALIGN_CHECK_EN
   assign w_misalign_s = (s_axil.awaddr[ALIGN_LSB-1:0] != {ALIGN_LSB{1'b0}});
   assign r_misalign_s = (s_axil.araddr[ALIGN_LSB-1:0] != {ALIGN_LSB{1'b0}});
`else
   assign w_misalign_s = 1'b0;
   assign r_misalign_s = 1'b0;
`endif

   assign m_axi.awid    = ID_WIDTH'(WRITE_ID);
   assign m_axi.awaddr  = aw_addr_r;
   assign m_axi.awlen   = 8'd0;
   assign m_axi.awsize  = AXI_SIZE;
   assign m_axi.awburst = BURST_INCR;
   assign m_axi.awlock  = 1'b0;
   assign m_axi.awcache = CACHE_DEFAULT;
   assign m_axi.awprot  = aw_prot_r;
   assign m_axi.awvalid = awvalid_r;
   assign m_axi.wdata   = wdata_r;
   assign m_axi.wstrb   = wstrb_r;
   assign m_axi.wlast   = 1'b1;
   assign m_axi.wvalid  = wvalid_r;
   assign m_axi.bready  = bready_s;
   assign s_axil.awready = awready_s;
   assign s_axil.wready  = awready_s;
   assign s_axil.bvalid  = (w_state_r == W_BRESP);
   assign s_axil.bresp   = bresp_r;

   assign m_axi.arid    = ID_WIDTH'(READ_ID);
   assign m_axi.araddr  = ar_addr_r;
   assign m_axi.arlen   = 8'd0;
   assign m_axi.arsize  = AXI_SIZE;
   assign m_axi.arburst = BURST_INCR;
   assign m_axi.arlock  = 1'b0;
   assign m_axi.arcache = CACHE_DEFAULT;
   assign m_axi.arprot  = ar_prot_r;
   assign m_axi.arvalid = arvalid_r;
   assign m_axi.rready  = rready_s;
   assign s_axil.arready = arready_s;
   assign s_axil.rvalid  = (r_state_r == R_RESP);
   assign s_axil.rdata   = rdata_r;
   assign s_axil.rresp   = rresp_r;

   // Returned IDs and rlast carry no information for single-beat traffic.
   assign unused_s = ^{m_axi.bid, m_axi.rid, m_axi.rlast};

   // Write FSM next-state and handshake decode.
   always_comb begin
      w_next_s  = w_state_r;
      awready_s = 1'b0;
      bready_s  = 1'b0;
      case (w_state_r)
         W_IDLE: begin
            if (s_axil.awvalid && s_axil.wvalid && !rst) begin
               awready_s = 1'b1;
               if (w_misalign_s) begin
                  w_next_s = W_BRESP;
               end else begin
                  w_next_s = W_REQ;
               end
            end else begin
               w_next_s = W_IDLE;
            end
         end
         W_REQ: begin
            if ((!awvalid_r || m_axi.awready) && (!wvalid_r || m_axi.wready)) begin
               w_next_s = W_RESP;
            end else begin
               w_next_s = W_REQ;
            end
         end
         W_RESP: begin
            bready_s = 1'b1;
            if (m_axi.bvalid) begin
               w_next_s = W_BRESP;
            end else begin
               w_next_s = W_RESP;
            end
         end
         W_BRESP: begin
            if (s_axil.bready) begin
               w_next_s = W_IDLE;
            end else begin
               w_next_s = W_BRESP;
            end
         end
         default: w_next_s = W_IDLE;
      endcase
   end

   // Write state, request payload and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_r <= W_IDLE;
         aw_addr_r <= {ADDR_WIDTH{1'b0}};
         aw_prot_r <= 3'b000;
         wdata_r   <= {DATA_WIDTH{1'b0}};
         wstrb_r   <= {STRB_WIDTH{1'b0}};
         awvalid_r <= 1'b0;
         wvalid_r  <= 1'b0;
         bresp_r   <= RESP_OKAY;
      end else begin
         w_state_r <= w_next_s;
         if (awready_s) begin
            aw_addr_r <= s_axil.awaddr;
            aw_prot_r <= s_axil.awprot;
            wdata_r   <= s_axil.wdata;
            wstrb_r   <= s_axil.wstrb;
            awvalid_r <= !w_misalign_s;
            wvalid_r  <= !w_misalign_s;
            bresp_r   <= w_misalign_s ? RESP_SLVERR : RESP_OKAY;
         end else begin
            if (m_axi.awready) begin
               awvalid_r <= 1'b0;
            end
            if (m_axi.wready) begin
               wvalid_r <= 1'b0;
            end
            if (bready_s && m_axi.bvalid) begin
               bresp_r <= m_axi.bresp;
            end
         end
      end
   end

   // Read FSM next-state and handshake decode.
   always_comb begin
      r_next_s  = r_state_r;
      arready_s = 1'b0;
      rready_s  = 1'b0;
      case (r_state_r)
         R_IDLE: begin
            arready_s = !rst;
            if (s_axil.arvalid && !rst) begin
               if (r_misalign_s) begin
                  r_next_s = R_RESP;
               end else begin
                  r_next_s = R_REQ;
               end
            end else begin
               r_next_s = R_IDLE;
            end
         end
         R_REQ: begin
            if (m_axi.arready) begin
               r_next_s = R_DATA;
            end else begin
               r_next_s = R_REQ;
            end
         end
         R_DATA: begin
            rready_s = 1'b1;
            if (m_axi.rvalid) begin
               r_next_s = R_RESP;
            end else begin
               r_next_s = R_DATA;
            end
         end
         R_RESP: begin
            if (s_axil.rready) begin
               r_next_s = R_IDLE;
            end else begin
               r_next_s = R_RESP;
            end
         end
         default: r_next_s = R_IDLE;
      endcase
   end

   // Read state, request payload and returned data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_r <= R_IDLE;
         ar_addr_r <= {ADDR_WIDTH{1'b0}};
         ar_prot_r <= 3'b000;
         arvalid_r <= 1'b0;
         rdata_r   <= {DATA_WIDTH{1'b0}};
         rresp_r   <= RESP_OKAY;
      end else begin
         r_state_r <= r_next_s;
         if (arready_s && s_axil.arvalid) begin
            ar_addr_r <= s_axil.araddr;
            ar_prot_r <= s_axil.arprot;
            arvalid_r <= !r_misalign_s;
            if (r_misalign_s) begin
               rdata_r <= {DATA_WIDTH{1'b0}};
               rresp_r <= RESP_SLVERR;
            end
         end else begin
            if (m_axi.arready) begin
               arvalid_r <= 1'b0;
            end
            if (rready_s && m_axi.rvalid) begin
               rdata_r <= m_axi.rdata;
               rresp_r <= m_axi.rresp;
            end
         end
      end
   end

endmodule

// File: tb/tb_axil_to_axi_bridge.sv
// Self-checking bench: host-side AXI4-Lite driver, randomized AXI4 RAM responder
// and a word-level memory model providing expected responses and read data.
module tb_axil_to_axi_bridge;
   import axi_bridge_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axil_if #(.ADDR_WIDTH(20), .DATA_WIDTH(32)) s ();
   axi_if  #(.ID_WIDTH(8), .ADDR_WIDTH(20), .DATA_WIDTH(32)) m ();

   axil_to_axi_bridge #(
      .DATA_WIDTH(32), .ADDR_WIDTH(20), .ID_WIDTH(8), .WRITE_ID(0), .READ_ID(0)
   ) dut (
      .clk(clk), .rst(rst), .s_axil(s), .m_axi(m)
   );

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   logic [31:0] ram   [int];
   logic [31:0] model [int];
   logic [19:0] aw_q[$];
   logic [35:0] w_q[$];
   logic [19:0] ar_q[$];
   int  aw_cnt = 0;
   int  ar_cnt = 0;
   bit  stall_m = 1'b0;
   logic [2:0] wr_prot, rd_prot;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] resp_of(input logic [19:0] a);
      case (a[19:16])
         4'hF:    return RESP_DECERR;
         4'hE:    return RESP_SLVERR;
         default: return RESP_OKAY;
      endcase
   endfunction

   // Response the whole bridge+RAM path must produce for an access.
   function automatic logic [1:0] exp_resp(input logic [19:0] a);
`ifdef AXIL_TO_AXI_BRIDGE_ALIGN_CHECK_EN
      if (a[1:0] != 2'b00) return RESP_SLVERR;
`endif
      return resp_of(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_d;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [19:0] rand_addr();
      logic [19:0] a;
      a = 20'($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 7) == 0) a[19:16] = ($urandom_range(0, 1) == 1) ? 4'hE : 4'hF;
      return a;
   endfunction

   // Downstream AXI4 RAM: random ready, random read latency, checks constant AXI4 fields.
   initial begin
      logic [19:0] a;
      logic [35:0] wd;
      int r_wait;
      bit b_clr, r_clr;
      r_wait = 0; b_clr = 1'b0; r_clr = 1'b0;
      m.awready = 1'b0; m.wready = 1'b0; m.bid = 8'h00; m.bresp = 2'b00; m.bvalid = 1'b0;
      m.arready = 1'b0; m.rid = 8'h00; m.rdata = 32'h0; m.rresp = 2'b00; m.rlast = 1'b0;
      m.rvalid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            aw_q.delete(); w_q.delete(); ar_q.delete();
            b_clr = 1'b0; r_clr = 1'b0;
            m.awready = 1'b0; m.wready = 1'b0; m.arready = 1'b0;
            m.bvalid = 1'b0; m.rvalid = 1'b0;
         end else begin
            if (b_clr) begin m.bvalid = 1'b0; b_clr = 1'b0; end
            if (r_clr) begin m.rvalid = 1'b0; r_clr = 1'b0; end
            if (!m.bvalid && aw_q.size() > 0 && w_q.size() > 0) begin
               a = aw_q.pop_front();
               wd = w_q.pop_front();
               m.bresp = resp_of(a);
               m.bid = 8'($urandom);
               if (m.bresp == RESP_OKAY)
                  ram[int'(a[19:2])] = merge(ram.exists(int'(a[19:2])) ? ram[int'(a[19:2])] : 32'h0,
                                             wd[31:0], wd[35:32]);
               m.bvalid = 1'b1;
            end
            if (!m.rvalid && ar_q.size() > 0) begin
               if (r_wait > 0) begin
                  r_wait--;
               end else begin
                  a = ar_q.pop_front();
                  m.rresp = resp_of(a);
                  m.rdata = (m.rresp == RESP_OKAY && ram.exists(int'(a[19:2]))) ?
                            ram[int'(a[19:2])] : 32'h0;
                  m.rlast = 1'($urandom);
                  m.rid = 8'($urandom);
                  m.rvalid = 1'b1;
                  r_wait = $urandom_range(0, 2);
               end
            end
            m.awready = !stall_m && ($urandom_range(0, 3) != 0);
            m.wready  = !stall_m && ($urandom_range(0, 3) != 0);
            m.arready = !stall_m && ($urandom_range(0, 3) != 0);
            #1;
            if (m.awvalid && m.awready) begin
               aw_q.push_back(m.awaddr);
               aw_cnt++;
               check("aw_fields", 64'({m.awid, m.awlen, m.awsize, m.awburst, m.awlock, m.awcache}),
                     64'({8'h00, 8'h00, 3'd2, 2'b01, 1'b0, 4'b0011}));
               check("aw_prot", 64'(m.awprot), 64'(wr_prot));
            end
            if (m.wvalid && m.wready) begin
               w_q.push_back({m.wstrb, m.wdata});
               check("wlast", 64'(m.wlast), 64'(1'b1));
            end
            if (m.arvalid && m.arready) begin
               ar_q.push_back(m.araddr);
               ar_cnt++;
               check("ar_fields", 64'({m.arid, m.arlen, m.arsize, m.arburst, m.arlock, m.arcache}),
                     64'({8'h00, 8'h00, 3'd2, 2'b01, 1'b0, 4'b0011}));
               check("ar_prot", 64'(m.arprot), 64'(rd_prot));
            end
            if (m.bvalid && m.bready) b_clr = 1'b1;
            if (m.rvalid && m.rready) r_clr = 1'b1;
         end
      end
   end

   // Waits for bvalid, optionally stalls bready while probing for a premature new accept.
   task automatic wait_b(input int hold, output logic [1:0] resp);
      bit ok, stable;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (s.bvalid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("b_seen", 64'(ok), 64'(1'b1));
      resp = s.bresp;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         s.awvalid = 1'b1; s.wvalid = 1'b1;
         #1;
         stable &= s.bvalid && (s.bresp == resp) && !s.awready;
         @(negedge clk);
      end
      if (hold > 0) check("b_hold_stable", 64'(stable), 64'(1'b1));
      s.awvalid = 1'b0; s.wvalid = 1'b0;
      s.bready = 1'b1;
      @(negedge clk);
      s.bready = 1'b0;
   endtask

   task automatic axil_write(input logic [19:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold, output logic [1:0] resp);
      bit ok;
      @(negedge clk);
      s.awaddr = addr; s.awprot = 3'($urandom); wr_prot = s.awprot;
      s.wdata = data; s.wstrb = strb; s.awvalid = 1'b1; s.wvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (s.awready && s.wready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("aw_accept", 64'(ok), 64'(1'b1));
      @(negedge clk);
      s.awvalid = 1'b0; s.wvalid = 1'b0;
      wait_b(hold, resp);
   endtask

   task automatic axil_read(input logic [19:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp);
      bit ok, stable;
      @(negedge clk);
      s.araddr = addr; s.arprot = 3'($urandom); rd_prot = s.arprot; s.arvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (s.arready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("ar_accept", 64'(ok), 64'(1'b1));
      @(negedge clk);
      s.arvalid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (s.rvalid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("r_seen", 64'(ok), 64'(1'b1));
      data = s.rdata; resp = s.rresp;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         s.arvalid = 1'b1;
         #1;
         stable &= s.rvalid && (s.rdata == data) && (s.rresp == resp) && !s.arready;
         @(negedge clk);
      end
      if (hold > 0) check("r_hold_stable", 64'(stable), 64'(1'b1));
      s.arvalid = 1'b0;
      s.rready = 1'b1;
      @(negedge clk);
      s.rready = 1'b0;
   endtask

   task automatic do_write(input logic [19:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
      logic [1:0] exp, resp;
      int idx;
      exp = exp_resp(addr);
      axil_write(addr, data, strb, hold, resp);
      check("bresp", 64'(resp), 64'(exp));
      idx = int'(addr[19:2]);
      if (exp == RESP_OKAY)
         model[idx] = merge(model.exists(idx) ? model[idx] : 32'h0, data, strb);
   endtask

   task automatic do_read(input logic [19:0] addr, input int hold);
      logic [1:0]  exp, resp;
      logic [31:0] exp_d, data;
      int idx;
      idx = int'(addr[19:2]);
      exp = exp_resp(addr);
      exp_d = (exp == RESP_OKAY && model.exists(idx)) ? model[idx] : 32'h0;
      axil_read(addr, hold, data, resp);
      check("rresp", 64'(resp), 64'(exp));
      check("rdata", 64'(data), 64'(exp_d));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] data;
      logic [19:0] wa;
      bit early;
      int cnt0;
      s.awaddr = 20'h0; s.awprot = 3'b000; s.awvalid = 1'b0; s.wdata = 32'h0; s.wstrb = 4'h0;
      s.wvalid = 1'b0; s.bready = 1'b0; s.araddr = 20'h0; s.arprot = 3'b000; s.arvalid = 1'b0;
      s.rready = 1'b0;
      wr_prot = 3'b000; rd_prot = 3'b000;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_valids", 64'({m.awvalid, m.wvalid, m.arvalid, s.bvalid, s.rvalid}), 64'(5'b0));
      check("rst_readies", 64'({m.bready, m.rready, s.arready, s.awready}), 64'(4'b0));
      check("rst_payload", 64'({s.bresp, s.rresp, s.rdata}), 64'(36'h0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arready_after_rst", 64'(s.arready), 64'(1'b1));

      axil_write(20'h00100, 32'hDEADBEEF, 4'hF, 0, resp);
      check("bresp_100", 64'(resp), 64'(RESP_OKAY));
      model[int'(20'h00100 >> 2)] = 32'hDEADBEEF;
      axil_read(20'h00100, 0, data, resp);
      check("rdata_100", 64'(data), 64'(32'hDEADBEEF));
      check("rresp_100", 64'(resp), 64'(RESP_OKAY));

      do_write(20'h00104, 32'hAABBCCDD, 4'hF, 0);
      do_write(20'h00104, 32'h11223344, 4'h3, 0);
      axil_read(20'h00104, 0, data, resp);
      check("rdata_104_strb", 64'(data), 64'(32'hAABB3344));

      // AW presented alone must wait for W.
      @(negedge clk);
      s.awaddr = 20'h0010C; s.awprot = 3'b101; wr_prot = 3'b101;
      s.wdata = 32'h0BADF00D; s.wstrb = 4'hF; s.awvalid = 1'b1; s.wvalid = 1'b0;
      early = 1'b0;
      repeat (5) begin
         #1;
         early |= s.awready;
         @(negedge clk);
      end
      check("aw_alone_no_ready", 64'(early), 64'(1'b0));
      s.wvalid = 1'b1;
      #1;
      check("aw_w_same_cycle", 64'({s.awready, s.wready}), 64'(2'b11));
      @(posedge clk);
      #1;
      check("m_valids_t1", 64'({m.awvalid, m.wvalid}), 64'(2'b11));
      s.awvalid = 1'b0; s.wvalid = 1'b0;
      wait_b(0, resp);
      check("bresp_10c", 64'(resp), 64'(RESP_OKAY));
      model[int'(20'h0010C >> 2)] = 32'h0BADF00D;
      do_read(20'h0010C, 0);

      do_write(20'h00200, $urandom, 4'hF, 10);
      do_read(20'h00200, 10);

      // Reset while the write sits in W_REQ.
      stall_m = 1'b1;
      @(negedge clk);
      s.awaddr = 20'h00008; s.wdata = 32'hFFFFFFFF; s.wstrb = 4'hF;
      s.awvalid = 1'b1; s.wvalid = 1'b1;
      #1;
      check("rst_test_accept", 64'(s.awready), 64'(1'b1));
      @(negedge clk);
      s.awvalid = 1'b0; s.wvalid = 1'b0;
      #1;
      check("in_w_req", 64'({m.awvalid, m.wvalid}), 64'(2'b11));
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("mid_rst_valids", 64'({m.awvalid, m.wvalid, m.arvalid, s.bvalid, s.rvalid,
                                   m.bready, m.rready}), 64'(7'b0));
      rst = 1'b0;
      #1;
      check("mid_rst_read_idle", 64'(s.arready), 64'(1'b1));
      stall_m = 1'b0;
      do_write(20'h00008, 32'h5A5A0008, 4'hF, 0);
      do_read(20'h00008, 0);

      for (int n = 0; n < 30; n++) begin
         wa = rand_addr();
         case ($urandom_range(0, 2))
            0: do_write(wa, $urandom, 4'($urandom_range(1, 15)), 0);
            1: do_read(wa, 0);
            default: begin
               fork
                  do_write(wa, $urandom, 4'hF, 0);
                  do_read(wa ^ 20'h00100, 0);
               join
            end
         endcase
      end

      cnt0 = ar_cnt;
      do_read(20'h00102, 0);
      cnt0 = aw_cnt;
      do_write(20'h00106, 32'hC0FFEE00, 4'hF, 0);
`ifdef AXIL_TO_AXI_BRIDGE_ALIGN_CHECK_EN
      check("misaligned_no_aw", 64'(aw_cnt), 64'(cnt0));
`else
      check("misaligned_forwarded_aw", 64'(aw_cnt), 64'(cnt0 + 1));
`endif
      cnt0 = ar_cnt;
      do_read(20'h00102, 0);
`ifdef AXIL_TO_AXI_BRIDGE_ALIGN_CHECK_EN
      check("misaligned_no_ar", 64'(ar_cnt), 64'(cnt0));
`else
      check("misaligned_forwarded_ar", 64'(ar_cnt), 64'(cnt0 + 1));
`endif
      do_read(20'h00104, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
